// File: rtl/dynamicisor.sv
// rtl/dynamicisor.sv - static word to LSB-first bit-serial digit stream with one-deep holding buffer
module dynamicisor #(
    parameter int WIDTH = 32,
    parameter int GAP   = 8
) (
    input  logic             w_CLK,
    input  logic             w_RST_N,
    input  logic             ready,
    input  logic             w_LOAD,
    input  logic [WIDTH-1:0] b_DYN_in,
    output logic             w_FULL,
    output logic             w_BUSY,
    output logic             w_DYN_out,
    output logic             w_DYN_valid,
    output logic             w_SOW,
    output logic             w_EOW
);

    localparam int CW = (WIDTH + GAP > 1) ? $clog2(WIDTH + GAP) : 1;
    localparam logic [CW-1:0] LAST_DATA = CW'(WIDTH - 1);
    localparam logic [CW-1:0] LAST_GAP  = (GAP > 0) ? CW'(GAP - 1) : '0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_GAP
    } state_t;

    state_t           state;
    state_t           nxt_state;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    nxt_cnt;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] nxt_shreg;
    logic [WIDTH-1:0] hold_q;
    logic             drain;
    logic             load_buf;

    // Loads that arrive while the shifter is working land in the holding buffer;
    // the buffer is drained at the edge closing a word, or from IDLE if one got parked there.
    always_comb begin
        nxt_state = state;
        nxt_cnt   = cnt;
        nxt_shreg = shreg;
        drain     = 1'b0;
        case (state)
            S_IDLE: begin
                nxt_cnt = '0;
                if (w_FULL) begin
                    nxt_state = S_DATA;
                    nxt_shreg = hold_q;
                    drain     = 1'b1;
                end else if (w_LOAD) begin
                    nxt_state = S_DATA;
                    nxt_shreg = b_DYN_in;
                end
            end
            S_DATA: begin
                if (cnt == LAST_DATA) begin
                    nxt_cnt = '0;
                    if (GAP > 0) begin
                        nxt_state = S_GAP;
                    end else if (w_FULL) begin
                        nxt_state = S_DATA;
                        nxt_shreg = hold_q;
                        drain     = 1'b1;
                    end else begin
                        nxt_state = S_IDLE;
                    end
                end else begin
                    nxt_cnt   = cnt + CW'(1);
                    nxt_shreg = shreg >> 1;
                end
            end
            S_GAP: begin
                if (cnt == LAST_GAP) begin
                    nxt_cnt = '0;
                    if (w_FULL) begin
                        nxt_state = S_DATA;
                        nxt_shreg = hold_q;
                        drain     = 1'b1;
                    end else begin
                        nxt_state = S_IDLE;
                    end
                end else begin
                    nxt_cnt = cnt + CW'(1);
                end
            end
            default: begin
                nxt_state = S_IDLE;
                nxt_cnt   = '0;
            end
        endcase
        load_buf = w_LOAD && !w_FULL && (state != S_IDLE);
    end

    // Outputs are registered copies of what the next state will present.
    always_ff @(posedge w_CLK) begin
        if (!w_RST_N) begin
            state       <= S_IDLE;
            cnt         <= '0;
            shreg       <= '0;
            hold_q      <= '0;
            w_FULL      <= 1'b0;
            w_BUSY      <= 1'b0;
            w_DYN_out   <= 1'b0;
            w_DYN_valid <= 1'b0;
            w_SOW       <= 1'b0;
            w_EOW       <= 1'b0;
        end else if (ready) begin
            state <= nxt_state;
            cnt   <= nxt_cnt;
            shreg <= nxt_shreg;
            if (load_buf) begin
                hold_q <= b_DYN_in;
            end
            if (drain) begin
                w_FULL <= 1'b0;
            end else if (load_buf) begin
                w_FULL <= 1'b1;
            end
            w_BUSY      <= (nxt_state != S_IDLE);
            w_DYN_out   <= (nxt_state == S_DATA) && nxt_shreg[0];
            w_DYN_valid <= (nxt_state == S_DATA);
            w_SOW       <= (nxt_state == S_DATA) && (nxt_cnt == '0);
            w_EOW       <= (nxt_state == S_DATA) && (nxt_cnt == LAST_DATA);
        end
    end

endmodule

// File: doc/dynamicisor.md
# dynamicisor

- Converts a static parallel word into a bit-serial digit stream, LSB first. Emits one digit per `ready` cycle, and each word is followed by a blank gap.
- It is the transmit-side counterpart of the staticisor: the staticisor turns a serial/dynamic word into a static register, and this block turns static data back into dynamic form.
- A one-deep holding buffer lets upstream queue the next word while the current one is shifting, giving a continuous word-period stream.

## Interface

Parameters:
- WIDTH, 32, data digits per word.
- GAP, 8, blank digit periods after each word (0 allowed).

Ports:
- w_CLK  input  1  clock.
- w_RST_N  input  1  reset; one clock, synchronous, active-low.
- ready  input  1  digit-period enable. All state changes except reset occur only on w_CLK edges where ready=1 ("ready edge").
- w_LOAD  input  1  load request for b_DYN_in.
- b_DYN_in  input  WIDTH  parallel word to serialise.
- w_FULL  output  1  holding buffer occupied. While high, loads are ignored.
- w_BUSY  output  1  shifter not IDLE.
- w_DYN_out  output  1  serial digit.
- w_DYN_valid  output  1  w_DYN_out carries a data digit.
- w_SOW  output  1  start of word: high during digit 0.
- w_EOW  output  1  end of word: high during digit WIDTH-1.

## Operation

- State machine with three states:
  - IDLE → DATA on a transfer.
  - DATA → GAP after digit WIDTH-1 when GAP>0.
  - DATA → IDLE, or directly to the next DATA word, after digit WIDTH-1 when GAP=0.
  - GAP → IDLE, or to the next DATA word, after gap digit GAP-1.
- Digit counter is sized ceil(log2(WIDTH+GAP)). It is 0 at DATA entry, increments each ready edge, and is cleared when the state changes.
- Shift register loads the word on transfer and shifts right each DATA ready edge, so bit 0 is emitted first.
- Load acceptance: on a ready edge with w_LOAD=1 and registered w_FULL=0.
  - If the shifter is IDLE and the buffer is empty, the word goes directly to the shifter (bypass).
  - Otherwise the word goes to the holding buffer and w_FULL is set.
- Buffer drain: at the ready edge that ends the final digit of a word, a full buffer transfers to the shifter and w_FULL clears.
  - With GAP>0, the final digit is gap digit GAP-1.
  - With GAP=0, it is data digit WIDTH-1.
  - The next word's digit 0 follows with no idle cycle.
- A load presented on the same edge the buffer drains is ignored, because w_FULL was still 1. Upstream must hold w_LOAD until it sees w_FULL=0.
- Loads on non-ready cycles are ignored. b_DYN_in is sampled only on the accepting ready edge.
- During GAP and IDLE: w_DYN_out=0 and w_DYN_valid=0.
- Reset is honoured regardless of ready, including mid-word or mid-gap. The in-flight word and the buffered word are discarded.

## Timing

- All outputs are registered. Reset values: w_FULL=0, w_BUSY=0, w_DYN_out=0, w_DYN_valid=0, w_SOW=0, w_EOW=0. State resets to IDLE, counter to 0, buffer empty.
- Bypass latency: digit 0 (with w_SOW=1 and w_DYN_valid=1) is on the outputs in the cycle after the accepting ready edge.
- Digit k is presented after the k-th ready edge following digit 0. Outputs hold steady across non-ready cycles.
- Word period is WIDTH+GAP ready edges.
  - w_DYN_valid is high for exactly WIDTH digits.
  - w_SOW and w_EOW are each high for exactly one digit.
  - If WIDTH=1, w_SOW and w_EOW are high together.
- w_BUSY rises with digit 0. It falls after the last gap digit, or after digit WIDTH-1 when GAP=0, unless a buffered word transfers.
- w_FULL rises one edge after a buffered load and falls on the drain edge.

## Test plan

- Bypass, WIDTH=32, GAP=8, ready=1: load 0x0000_0005 from IDLE.
  - Stream is 1,0,1 then 29 zeros, with w_DYN_valid high 32 cycles and w_SOW on the first.
  - 8 gap cycles follow with valid=0, then w_BUSY=0.
- Back-to-back: load 0xFFFF_FFFF, then load 0x8000_0001 during digit 3.
  - w_FULL=1 until the end of gap digit 7.
  - Second word's digit 0 (value 1) immediately follows the gap, and digit 31 is 1.
- Ready throttling: ready high every 3rd cycle, load 0xA.
  - Each digit holds for 3 cycles.
  - Sequence is 0,1,0,1,0... and the counter advances only on ready edges.
- GAP=0, WIDTH=4: preload two words 0x3 and 0xC.
  - Output is 1,1,0,0,0,0,1,1 contiguous, with w_EOW at positions 3 and 7 and w_SOW at 0 and 4.
- Overflow: with the buffer full, pulse w_LOAD with 0x1234.
  - Word is ignored; the buffered word is the one emitted next.
  - Load on the drain edge is also ignored.
- Reset mid-word (digit 10) with the buffer full: deassert w_RST_N for one clock with ready=0.
  - All outputs are 0 and w_FULL=0 the next cycle.
  - No residual digits are emitted afterwards.
